inst_encoder: RTL
=================

# inst_encoder

Packs decoded instruction fields into 19-bit instruction words and streams them into instruction memory, one word per address starting at a programmable base. It is the program-load side of the instruction path: its bit layout is exactly what the instruction register splits apart on fetch. A small FSM controls each load burst, a one-entry output register feeds a held-until-acked write port, and the block drops and flags illegal encodings.

## Interface
- ADDR_W, 8: instruction memory address width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin burst; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address, latched on start.
- length  in  ADDR_W  number of legal words to write, latched on start.
- abort  in  1  terminate burst immediately.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted on the clock edge where in_valid && in_ready.
- in_opcode  in  5  opcode.
- in_rs1, in_rs2, in_rd  in  4 each  register fields.
- in_imm  in  14  address/immediate or LD/ST offset.
- in_boff  in  6  branch offset.
- mem_we  out  1  write request; held until acked.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  19  encoded word.
- mem_ack  in  1  write completes on the edge where mem_we && mem_ack.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  one-cycle pulse, registered on the edge after an illegal bundle is accepted.

## Operation
- Encoding: word[18:14] = opcode. All bits not listed for an opcode are 0. Unused inputs must not affect the word.
  - Opcodes 0–9 (ALU): [13:10]=rs1, [9:6]=rs2, [5:2]=rd, [1:0]=0.
  - Opcodes 10–11 (LD/ST): [13:10]=rs1, [9:6]=rs2, [5:0]=imm[5:0]. The bundle is illegal if imm[13:6] != 0.
  - Opcodes 12–13 (BEQ/BNE): [13:10]=rs1, [9:6]=rs2, [5:0]=boff.
  - Opcodes 14–15 (JMP/CALL): [13:0]=imm.
  - Opcodes 16–31: illegal.
- Illegal bundle: it is accepted (consumed) but not written and not counted; err pulses.
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on start. Latch base_addr and length; clear the index.
  - RUN → DONE when the accepted count equals length and the output register is empty.
  - DONE → IDLE after exactly one cycle, with done=1 during that cycle.
- length=0: start goes IDLE → RUN → DONE with no writes and in_ready never asserted.
- in_ready = RUN && accepted < length && (output register empty || mem_ack).
  - Back-to-back acceptance with single-cycle ack gives one word per cycle.
- mem_addr = base_addr + index, modulo 2^ADDR_W (wraps silently). The index increments on each legal accept.
- start in RUN or DONE is ignored.
- abort (any state):
  - next state is IDLE and the output register is cleared, which drops mem_we;
  - done does not pulse, and an in-flight unacked write is discarded;
  - abort has priority over accept and start in the same cycle.
- Reset values: state IDLE; in_ready, mem_we, busy, done and err all 0; mem_addr = 0; mem_wdata = 0; counters 0.

## Timing
- Accept at edge k → mem_we=1 with valid mem_addr/mem_wdata from edge k (visible in cycle k+1).
- mem_we, mem_addr and mem_wdata are stable until the acking edge.
- A new accept on the acking edge reloads the register, so mem_we stays high.
- err is asserted in the cycle after accepting an illegal bundle; mem_we is unaffected.
- busy is high for the whole of RUN. done is high for the single DONE cycle, which follows the last ack edge.
- Reset assertion mid-burst returns all outputs to their reset values asynchronously.

## Test plan
- ALU encode: start base=0x10 len=1, ADD rs1=3 rs2=5 rd=7 → one write, mem_addr=0x10, mem_wdata=19'h00D5C, then a done pulse.
- Mixed burst, len=3, mem_ack tied 1, in_valid continuous → in_ready high for 3 consecutive cycles; writes at 0x20, 0x21, 0x22:
  - JMP imm=0x1234 → 19'h39234;
  - LD rs1=2 rs2=4 imm=0x3F → 19'h2893F;
  - BNE rs1=1 rs2=1 boff=0x2A → 19'h3446A.
- Illegal drops, len=1:
  - opcode 16 → err pulse, no write;
  - LD imm=0x40 → err pulse, no write;
  - then ADD all zero → word 19'h00000 at base; done after it.
- Backpressure: hold mem_ack=0 for 4 cycles → mem_we, mem_addr and mem_wdata stable; in_ready=0; write completes on the first ack edge.
- Boundaries:
  - base=0xFF len=2 → writes at 0xFF then 0x00;
  - len=0 → done pulse 2 cycles after start with no mem_we.
- Abort/reset:
  - abort with mem_we pending → mem_we drops next cycle, state IDLE, no done;
  - rst_n low mid-burst → all outputs 0 immediately; a new start works normally.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction fields into 19-bit words and streams
// them into instruction memory from a programmable base address, one word per
// address. Illegal bundles are consumed, dropped and flagged on err.
module inst_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_rs2,
    input  logic [3:0]        in_rd,
    input  logic [13:0]       in_imm,
    input  logic [5:0]        in_boff,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [18:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned WORD_W = 19;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WORD_W-1:0]   word_c;
    logic                legal_c;
    logic                accept_c;

    // Field packing and legality check for the bundle currently on the inputs
    always_comb begin
        word_c        = '0;
        legal_c       = 1'b1;
        word_c[18:14] = in_opcode;
        if (in_opcode < 5'd10) begin
            word_c[13:10] = in_rs1;
            word_c[9:6]   = in_rs2;
            word_c[5:2]   = in_rd;
        end else if (in_opcode < 5'd12) begin
            word_c[13:10] = in_rs1;
            word_c[9:6]   = in_rs2;
            word_c[5:0]   = in_imm[5:0];
            legal_c       = (in_imm[13:6] == 8'd0);
        end else if (in_opcode < 5'd14) begin
            word_c[13:10] = in_rs1;
            word_c[9:6]   = in_rs2;
            word_c[5:0]   = in_boff;
        end else if (in_opcode < 5'd16) begin
            word_c[13:0]  = in_imm;
        end else begin
            legal_c       = 1'b0;
        end
    end

    // Ready depends on mem_ack so an acking edge can reload the output register
    assign in_ready = (state_q == S_RUN) && (cnt_q < len_q) && (!we_q || mem_ack);
    assign accept_c = in_ready && in_valid && !abort;

    // Next-state logic: burst control, output register load/drain, abort override
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;

        if (we_q && mem_ack) begin
            we_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    base_d  = base_addr;
                    len_d   = length;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (accept_c) begin
                    if (legal_c) begin
                        we_d   = 1'b1;
                        addr_d = ADDR_W'(base_q + cnt_q);
                        data_d = word_c;
                        cnt_d  = ADDR_W'(cnt_q + ADDR_W'(1));
                    end else begin
                        err_d  = 1'b1;
                    end
                end
                if ((cnt_q == len_q) && !we_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            we_d    = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            err_d   = 1'b0;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
